lcd1602_bus_monitor: RTL

- Passive receiver for the HD44780-compatible LCD1602 write bus that our display drivers generate.
- Samples LCD_EN/LCD_RS/LCD_RW/lcd_data in the system clock domain and decodes each transfer as an instruction or a character write.
- Maintains a 32-character shadow frame buffer (2×16) plus display-control state.
- Sits beside the physical panel, or in the bench in place of it; checkers and on-chip readback compare screen contents without the glass.

---
 rtl/lcd1602_pkg.sv | 56 +++++
 rtl/lcd_bus_sync.sv | 40 ++++
 rtl/lcd1602_bus_monitor.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/lcd1602_pkg.sv
// Shared definitions for the LCD1602 bus monitor: HD44780 opcode mask/match
// pairs, DDRAM address map constants, FSM state type, and helpers that map a
// DDRAM address to a frame-buffer index and step the address counter.
package lcd1602_pkg;

  localparam logic [7:0] OP_DDRAM_MASK  = 8'h80, OP_DDRAM_MATCH  = 8'h80;
  localparam logic [7:0] OP_CGRAM_MASK  = 8'hC0, OP_CGRAM_MATCH  = 8'h40;
  localparam logic [7:0] OP_FUNC_MASK   = 8'hE0, OP_FUNC_MATCH   = 8'h20;
  localparam logic [7:0] OP_SHIFT_MASK  = 8'hF0, OP_SHIFT_MATCH  = 8'h10;
  localparam logic [7:0] OP_DISP_MASK   = 8'hF8, OP_DISP_MATCH   = 8'h08;
  localparam logic [7:0] OP_ENTRY_MASK  = 8'hFC, OP_ENTRY_MATCH  = 8'h04;
  localparam logic [7:0] OP_HOME_MASK   = 8'hFE, OP_HOME_MATCH   = 8'h02;
  localparam logic [7:0] OP_CLEAR_MASK  = 8'hFF, OP_CLEAR_MATCH  = 8'h01;

  localparam logic [7:0]  CHAR_SPACE   = 8'h20;
  localparam logic [6:0]  LINE1_BASE   = 7'h40;
  localparam logic [6:0]  LINE_END0    = 7'h27;
  localparam logic [6:0]  LINE_END1    = 7'h67;
  localparam int unsigned VISIBLE_COLS = 16;

  typedef enum logic {ST_IDLE, ST_FILL} mon_state_t;

  typedef struct packed {
    logic       vis;
    logic [4:0] idx;
  } fb_index_t;

  // Line 0 columns 0x00-0x0F map to 0-15, line 1 columns 0x40-0x4F to 16-31.
  function automatic fb_index_t ac_to_index(input logic [6:0] a);
    fb_index_t r;
    r.vis = 1'b0;
    r.idx = '0;
    if (a < 7'(VISIBLE_COLS)) begin
      r.vis = 1'b1;
      r.idx = a[4:0];
    end else if (a >= LINE1_BASE && a < LINE1_BASE + 7'(VISIBLE_COLS)) begin
      r.vis = 1'b1;
      r.idx = 5'(a - LINE1_BASE + 7'(VISIBLE_COLS));
    end
    return r;
  endfunction

  // Two-line address wrap; addresses outside both lines step by plain +-1.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == LINE_END0)      return LINE1_BASE;
      else if (a == LINE_END1) return 7'h00;
      else                     return a + 7'd1;
    end else begin
      if (a == 7'h00)           return LINE_END1;
      else if (a == LINE1_BASE) return LINE_END0;
      else                      return a - 7'd1;
    end
  endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Bus front end: every LCD input passes through the same SYNC_STAGES flop
// chain so EN and RS/RW/data stay aligned; an EN 1->0 at the last stage
// produces a one-cycle ev_pulse with the matching fields.
// Ports: Clk, Rst (sync, active high), LCD_EN/RS/RW, lcd_data in;
//        ev_pulse, ev_rs, ev_rw, ev_data out.
module lcd_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       LCD_EN,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] lcd_data,
  output logic       ev_pulse,
  output logic       ev_rs,
  output logic       ev_rw,
  output logic [7:0] ev_data
);

  logic [10:0] pipe [SYNC_STAGES];
  logic        en_prev;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) pipe[i] <= '0;
      en_prev <= 1'b0;
    end else begin
      pipe[0] <= {LCD_EN, LCD_RS, LCD_RW, lcd_data};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) pipe[i] <= pipe[i-1];
      en_prev <= pipe[SYNC_STAGES-1][10];
    end
  end

  assign ev_pulse = en_prev & ~pipe[SYNC_STAGES-1][10];
  assign ev_rs    = pipe[SYNC_STAGES-1][9];
  assign ev_rw    = pipe[SYNC_STAGES-1][8];
  assign ev_data  = pipe[SYNC_STAGES-1][7:0];

endmodule

// File: rtl/lcd1602_bus_monitor.sv
// Passive LCD1602 write-bus monitor: decodes instructions and character
// writes into a 2x16 shadow frame buffer plus display-control state.
// Ports: Clk, Rst (sync, active high); LCD_EN/RS/RW, lcd_data bus inputs;
//        rd_addr -> rd_data (registered read); wr_stb/wr_pos/wr_char per
//        visible write; ac, disp_on, cursor_on, blink_on, func_cfg state;
//        busy during buffer fill; err sticky until Rst.
module lcd1602_bus_monitor
  import lcd1602_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       LCD_EN,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       wr_stb,
  output logic [4:0] wr_pos,
  output logic [7:0] wr_char,
  output logic [6:0] ac,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic [2:0] func_cfg,
  output logic       busy,
  output logic       err
);

  logic       ev, ev_rs, ev_rw;
  logic [7:0] ev_data;

  lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .Clk(Clk), .Rst(Rst), .LCD_EN(LCD_EN), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .lcd_data(lcd_data), .ev_pulse(ev), .ev_rs(ev_rs), .ev_rw(ev_rw),
    .ev_data(ev_data)
  );

  mon_state_t state_q, state_d;
  logic [4:0] fill_q, fill_d;
  logic       id_q, id_d, sh_q, sh_d;
  logic [6:0] ac_d;
  logic       disp_d, cursor_d, blink_d, err_d;
  logic [2:0] func_d;
  logic       stb_d;
  logic       fb_we;
  logic [4:0] fb_addr;
  logic [7:0] fb_wdata;
  fb_index_t  ac_map;
  logic [7:0] fb [32];

  assign ac_map = ac_to_index(ac);
  assign busy   = (state_q == ST_FILL);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= ST_FILL;
      fill_q    <= '0;
      ac        <= '0;
      id_q      <= 1'b1;
      sh_q      <= 1'b0;
      disp_on   <= 1'b0;
      cursor_on <= 1'b0;
      blink_on  <= 1'b0;
      func_cfg  <= '0;
      err       <= 1'b0;
      wr_stb    <= 1'b0;
      wr_pos    <= '0;
      wr_char   <= '0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      ac        <= ac_d;
      id_q      <= id_d;
      sh_q      <= sh_d;
      disp_on   <= disp_d;
      cursor_on <= cursor_d;
      blink_on  <= blink_d;
      func_cfg  <= func_d;
      err       <= err_d;
      wr_stb    <= stb_d;
      if (stb_d) begin
        wr_pos  <= fb_addr;
        wr_char <= fb_wdata;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    ac_d     = ac;
    id_d     = id_q;
    sh_d     = sh_q;
    disp_d   = disp_on;
    cursor_d = cursor_on;
    blink_d  = blink_on;
    func_d   = func_cfg;
    err_d    = err;
    stb_d    = 1'b0;
    fb_we    = 1'b0;
    fb_addr  = '0;
    fb_wdata = '0;
    case (state_q)
      ST_FILL: begin
        fb_we    = ~Rst;
        fb_addr  = fill_q;
        fb_wdata = CHAR_SPACE;
        if (fill_q == 5'd31) begin
          state_d = ST_IDLE;
          fill_d  = '0;
        end else begin
          fill_d = fill_q + 5'd1;
        end
        if (ev) err_d = 1'b1;
      end
      default: begin
        if (ev) begin
          if (ev_rw) begin
            err_d = 1'b1;
          end else if (ev_rs) begin
            if (ac_map.vis) begin
              fb_we    = ~Rst;
              fb_addr  = ac_map.idx;
              fb_wdata = ev_data;
              stb_d    = 1'b1;
            end
            ac_d = ac_step(ac, id_q);
          end else if ((ev_data & OP_DDRAM_MASK) == OP_DDRAM_MATCH) begin
            ac_d = ev_data[6:0];
          end else if ((ev_data & OP_CGRAM_MASK) == OP_CGRAM_MATCH) begin
          end else if ((ev_data & OP_FUNC_MASK) == OP_FUNC_MATCH) begin
            func_d = ev_data[4:2];
          end else if ((ev_data & OP_SHIFT_MASK) == OP_SHIFT_MATCH) begin
          end else if ((ev_data & OP_DISP_MASK) == OP_DISP_MATCH) begin
            {disp_d, cursor_d, blink_d} = ev_data[2:0];
          end else if ((ev_data & OP_ENTRY_MASK) == OP_ENTRY_MATCH) begin
            id_d = ev_data[1];
            sh_d = ev_data[0];
          end else if ((ev_data & OP_HOME_MASK) == OP_HOME_MATCH) begin
            ac_d = '0;
          end else if ((ev_data & OP_CLEAR_MASK) == OP_CLEAR_MATCH) begin
            ac_d    = '0;
            id_d    = 1'b1;
            state_d = ST_FILL;
            fill_d  = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (fb_we) fb[fb_addr] <= fb_wdata;
  end

  // Read uses the pre-write array contents, so a same-cycle write to the
  // same index shows up one cycle later.
  always_ff @(posedge Clk) begin
    if (Rst) rd_data <= '0;
    else     rd_data <= fb[rd_addr];
  end

endmodule
